// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared pipeline definitions for the forwarding / hazard logic.
//   FWD_*      : operand-mux select encodings (regfile, EX/MEM, MEM/WB)
//   REG_ADDR_W : architectural register-address width
//   slot_t     : per-stage record of the instruction occupying EX, MEM or WB
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp -- decides whether one producer slot can supply one source operand
// of the consumer sitting in EX.
//   prod_i       : producer slot record (MEM or WB)
//   src_i        : consumer source-register index
//   use_src_i    : consumer actually reads that source
//   cons_valid_i : consumer slot holds a real instruction
//   match_o      : producer result must be forwarded to this operand
module fwd_cmp
  import cpu_pkg::*;
(
  input  slot_t                 prod_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_src_i,
  input  logic                  cons_valid_i,
  output logic                  match_o
);

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  assign match_o = cons_valid_i & use_src_i
                 & prod_i.valid & prod_i.reg_write
                 & (prod_i.rd != '0) & (prod_i.rd == src_i);

  // Source fields of the producer play no part in the comparison.
  logic prod_unused;
  assign prod_unused = ^{prod_i.rs1, prod_i.rs2, prod_i.use_rs1,
                         prod_i.use_rs2, prod_i.mem_read};

endmodule

// File: rtl/forward_unit.sv
// forward_unit -- operand forwarding selects and load-use stall detection
// for a 5-stage in-order pipeline. Tracks the instructions in EX, MEM and WB.
//   clk, arst_n            : clock, asynchronous active-low reset
//   id_*                   : decoded fields of the instruction currently in ID
//   flush                  : taken branch, the ID instruction is killed
//   fwd_a_sel / fwd_b_sel  : operand mux selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall                  : hold PC and IF/ID this cycle
//   stall_cnt              : saturating count of load-use stall cycles
module forward_unit
  import cpu_pkg::slot_t;
  import cpu_pkg::FWD_RF;
  import cpu_pkg::FWD_EXMEM;
  import cpu_pkg::FWD_MEMWB;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  slot_t            ex_q, mem_q, wb_q;
  slot_t            id_slot, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
    id_slot.use_rs1   = id_use_rs1;
    id_slot.use_rs2   = id_use_rs2;
    id_slot.rd        = id_rd;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
  end

  // Load in EX whose result the ID instruction needs: the data only exists
  // after MEM, so ID waits one cycle and then picks it up from MEM/WB.
  assign hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
                & ((id_use_rs1 & (id_rs1 == ex_q.rd))
                 | (id_use_rs2 & (id_rs2 == ex_q.rd)));

  // A flushed instruction is dead, so it cannot be waiting for anything.
  assign stall = hazard & ~flush;

  always_comb begin
    ex_d = id_slot;
    if (flush || stall) begin
      ex_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

  // Operand 0 = A (rs1), operand 1 = B (rs2); each compared against MEM and WB.
  logic [1:0] match_mem;
  logic [1:0] match_wb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    logic [cpu_pkg::REG_ADDR_W-1:0] src;
    logic                           use_src;

    assign src     = (gi == 0) ? ex_q.rs1 : ex_q.rs2;
    assign use_src = (gi == 0) ? ex_q.use_rs1 : ex_q.use_rs2;

    fwd_cmp u_cmp_mem (
      .prod_i       (mem_q),
      .src_i        (src),
      .use_src_i    (use_src),
      .cons_valid_i (ex_q.valid),
      .match_o      (match_mem[gi])
    );

    fwd_cmp u_cmp_wb (
      .prod_i       (wb_q),
      .src_i        (src),
      .use_src_i    (use_src),
      .cons_valid_i (ex_q.valid),
      .match_o      (match_wb[gi])
    );
  end

  // The MEM producer is younger than WB, so its value is the current one.
  assign fwd_a_sel = match_mem[0] ? FWD_EXMEM : (match_wb[0] ? FWD_MEMWB : FWD_RF);
  assign fwd_b_sel = match_mem[1] ? FWD_EXMEM : (match_wb[1] ? FWD_MEMWB : FWD_RF);

  // Only the write-side fields of WB are ever consulted.
  logic wb_unused;
  assign wb_unused = ^{wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit -- directed-vector bench for forward_unit with a
// scoreboard queue: the driver pushes the hand-computed outputs expected for
// each cycle, the monitor pops and compares them on the falling edge (or on
// demand for checks taken while reset is asserted).
module tb_forward_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic          flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tag;
    logic [1:0]    a;
    logic [1:0]    b;
    logic          s;
    logic [CW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  // Monitor: one line per compared transaction.
  always begin
    @(negedge clk or chk_ev);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || stall !== e.s || stall_cnt !== e.c) begin
        n_fail++;
        $display("FAIL c%0d: got a=%b b=%b stall=%b cnt=%0d, expected a=%b b=%b stall=%b cnt=%0d",
                 e.tag, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.s, e.c);
      end else begin
        $display("ok   c%0d: a=%b b=%b stall=%b cnt=%0d", e.tag, fwd_a_sel, fwd_b_sel, stall, stall_cnt);
      end
    end
  end

  task automatic push_exp(input int tag, input logic [1:0] ea, input logic [1:0] eb,
                          input logic es, input logic [CW-1:0] ec);
    exp_t e;
    e.tag = tag; e.a = ea; e.b = eb; e.s = es; e.c = ec;
    exp_q.push_back(e);
  endtask

  // One pipeline cycle: present an ID instruction and the outputs expected.
  task automatic cyc(input int tag, input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic u1, input logic u2, input logic [AW-1:0] rd,
                     input logic rw, input logic mr, input logic fl,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es, input logic [CW-1:0] ec);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    push_exp(tag, ea, eb, es, ec);
  endtask

  task automatic nop(input int tag, input logic [1:0] ea, input logic [1:0] eb,
                     input logic es, input logic [CW-1:0] ec);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, es, ec);
  endtask

  // Reset pulse between clock edges; outputs are checked while it is low.
  task automatic rst_pulse(input int tag);
    @(negedge clk);
    #1 arst_n = 1'b0;
    #1;
    push_exp(tag, 2'b00, 2'b00, 1'b0, '0);
    -> chk_ev;
    #1 arst_n = 1'b1;
  endtask

  function automatic logic [CW-1:0] sat(input int x);
    return (x > 15) ? 4'd15 : x[CW-1:0];
  endfunction

  initial begin
    arst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    #2;
    push_exp(-1, 2'b00, 2'b00, 1'b0, '0);
    -> chk_ev;
    #10 arst_n = 1'b1;

    nop(0, 2'b00, 2'b00, 0, 0);
    // ADD x5 ; ADD x6,x5,x1 back-to-back
    cyc(1, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    cyc(2, 1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    nop(3, 2'b01, 2'b00, 0, 0);
    // ADD x5 ; NOP ; SUB x7,x1,x5
    cyc(4, 1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    nop(5, 2'b00, 2'b00, 0, 0);
    cyc(6, 1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    nop(7, 2'b00, 2'b10, 0, 0);
    // LW x8 ; ADD x9,x8,x8 (held in ID for the stall cycle)
    cyc(8,  1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    cyc(9,  1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'b00, 2'b00, 1, 0);
    cyc(10, 1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    nop(11, 2'b10, 2'b10, 0, 1);
    // x3 written by MEM and WB producers; writes to x0 never forwarded
    cyc(12, 1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    cyc(13, 1, 5'd4, 5'd4, 1, 1, 5'd3, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    cyc(14, 1, 5'd3, 5'd3, 1, 1, 5'd10, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    cyc(15, 1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0, 2'b01, 2'b01, 0, 1);
    cyc(16, 1, 5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    cyc(17, 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 2'b00, 2'b00, 0, 1);
    cyc(18, 1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    // load-use hazard coincident with flush
    cyc(19, 1, 5'd1, 5'd0, 1, 0, 5'd13, 1, 1, 0, 2'b00, 2'b00, 0, 1);
    cyc(20, 1, 5'd13, 5'd2, 1, 1, 5'd14, 1, 0, 1, 2'b00, 2'b00, 0, 1);
    nop(21, 2'b00, 2'b00, 0, 1);
    // load followed by an instruction that does not read its sources
    cyc(22, 1, 5'd2, 5'd0, 1, 0, 5'd16, 1, 1, 0, 2'b00, 2'b00, 0, 1);
    cyc(23, 1, 5'd16, 5'd16, 0, 0, 5'd17, 1, 0, 0, 2'b00, 2'b00, 0, 1);
    nop(24, 2'b00, 2'b00, 0, 1);
    // load-use hazard through rs2 only
    cyc(25, 1, 5'd2, 5'd0, 1, 0, 5'd18, 1, 1, 0, 2'b00, 2'b00, 0, 1);
    cyc(26, 1, 5'd3, 5'd18, 1, 1, 5'd0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    cyc(27, 1, 5'd3, 5'd18, 1, 1, 5'd0, 0, 0, 0, 2'b00, 2'b00, 0, 2);
    nop(28, 2'b00, 2'b10, 0, 2);
    // reset in the middle of a stall
    cyc(29, 1, 5'd1, 5'd0, 1, 0, 5'd20, 1, 1, 0, 2'b00, 2'b00, 0, 2);
    cyc(30, 1, 5'd20, 5'd20, 1, 1, 5'd21, 1, 0, 0, 2'b00, 2'b00, 1, 2);
    rst_pulse(300);
    cyc(31, 1, 5'd21, 5'd1, 1, 1, 5'd22, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    nop(32, 2'b01, 2'b00, 0, 0);
    // counter saturation: LW x8,0(x8) repeated stalls every other cycle
    cyc(33, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    cyc(34, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 1, 0);
    for (int j = 0; j < 18; j++) begin
      cyc(35 + 2*j, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, sat(1 + j));
      cyc(36 + 2*j, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b10, 2'b00, 1, sat(1 + j));
    end
    cyc(71, 1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'b00, 2'b00, 0, 4'd15);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
